// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register file.
package regfile_scoreboard_pkg;

    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [$clog2(NUM_REGS)-1:0] t_reg_addr;

    localparam t_reg_addr REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/write-back side bundle for the register file and scoreboard.
interface regfile_scoreboard_if #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned NUM_REGS     = 32,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned NUM_WR_PORTS = 1
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_RD_PORTS*AW-1:0]        i_rd_addr;
    logic [NUM_RD_PORTS*DATA_SIZE-1:0] o_rd_data;
    logic [NUM_RD_PORTS-1:0]           o_rd_hazard;
    logic [NUM_WR_PORTS-1:0]           i_wr_en;
    logic [NUM_WR_PORTS*AW-1:0]        i_wr_addr;
    logic [NUM_WR_PORTS*DATA_SIZE-1:0] i_wr_data;
    logic                              i_issue_valid;
    logic [AW-1:0]                     i_issue_rd;
    logic                              i_flush;
    logic [NUM_REGS-1:0]               o_pending;

    modport master (
        output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
               i_issue_valid, i_issue_rd, i_flush,
        input  o_rd_data, o_rd_hazard, o_pending
    );

    modport slave (
        input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
               i_issue_valid, i_issue_rd, i_flush,
        output o_rd_data, o_rd_hazard, o_pending
    );

endinterface

// File: rtl/regfile_scoreboard_bypass_mux.sv
// One read port: picks same-cycle write data over array data and
// qualifies the pending bit into a hazard.
module regfile_bypass_mux #(
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned NUM_WR_PORTS = 1,
    parameter int unsigned BYPASS       = 1
) (
    input  logic                              bypass_en,
    input  logic [AW-1:0]                     rd_addr,
    input  logic [DATA_SIZE-1:0]              array_data,
    input  logic                              pending_bit,
    input  logic [NUM_WR_PORTS-1:0]           wr_en,
    input  logic [NUM_WR_PORTS*AW-1:0]        wr_addr,
    input  logic [NUM_WR_PORTS*DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0]              rd_data,
    output logic                              rd_hazard
);

    logic hit;

    // Later (higher-index) write ports override earlier ones; x0 always reads 0.
    always_comb begin
        rd_data = array_data;
        hit     = 1'b0;
        if ((BYPASS != 0) && bypass_en && (rd_addr != '0)) begin
            for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                if (wr_en[w] && (wr_addr[w*AW +: AW] == rd_addr)) begin
                    rd_data = wr_data[w*DATA_SIZE +: DATA_SIZE];
                    hit     = 1'b1;
                end
            end
        end
        if (rd_addr == '0) begin
            rd_data = '0;
        end
        rd_hazard = pending_bit && !hit;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and pending-write scoreboard.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = regfile_scoreboard_pkg::DATA_SIZE,
    parameter int unsigned NUM_REGS     = regfile_scoreboard_pkg::NUM_REGS,
    parameter int unsigned NUM_RD_PORTS = 2,
    parameter int unsigned NUM_WR_PORTS = 1,
    parameter int unsigned BYPASS       = 1
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    regfile_scoreboard_if.slave  bus
);

    localparam int unsigned   AW        = $clog2(NUM_REGS);
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [DATA_SIZE-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]  pending;
    logic [NUM_REGS-1:0]  pending_nxt;
    logic [AW-1:0]        wa [NUM_WR_PORTS];
    logic [DATA_SIZE-1:0] wd [NUM_WR_PORTS];
    logic [DATA_SIZE-1:0] rd_data_arr [NUM_RD_PORTS];
    logic                 rd_hazard_arr [NUM_RD_PORTS];

    // Unpack the flat write-back buses.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            wa[w] = bus.i_wr_addr[w*AW +: AW];
            wd[w] = bus.i_wr_data[w*DATA_SIZE +: DATA_SIZE];
        end
    end

    // Register array; ascending port order makes the highest port win.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
                if (bus.i_wr_en[w] && (wa[w] != ZERO_ADDR)) begin
                    regs[wa[w]] <= wd[w];
                end
            end
        end
    end

    // Scoreboard next state: later assignments carry higher priority
    // (write-back clear < issue set < flush).
    always_comb begin
        pending_nxt = pending;
        for (int unsigned w = 0; w < NUM_WR_PORTS; w++) begin
            if (bus.i_wr_en[w]) begin
                pending_nxt[wa[w]] = 1'b0;
            end
        end
        if (bus.i_issue_valid) begin
            pending_nxt[bus.i_issue_rd] = 1'b1;
        end
        if (bus.i_flush) begin
            pending_nxt = '0;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard state register.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        regfile_bypass_mux #(
            .DATA_SIZE    (DATA_SIZE),
            .AW           (AW),
            .NUM_WR_PORTS (NUM_WR_PORTS),
            .BYPASS       (BYPASS)
        ) u_mux (
            .bypass_en   (i_areset_n),
            .rd_addr     (bus.i_rd_addr[p*AW +: AW]),
            .array_data  (regs[bus.i_rd_addr[p*AW +: AW]]),
            .pending_bit (pending[bus.i_rd_addr[p*AW +: AW]]),
            .wr_en       (bus.i_wr_en),
            .wr_addr     (bus.i_wr_addr),
            .wr_data     (bus.i_wr_data),
            .rd_data     (rd_data_arr[p]),
            .rd_hazard   (rd_hazard_arr[p])
        );
    end

    // Pack per-port results onto the flat output buses.
    always_comb begin
        for (int unsigned p = 0; p < NUM_RD_PORTS; p++) begin
            bus.o_rd_data[p*DATA_SIZE +: DATA_SIZE] = rd_data_arr[p];
            bus.o_rd_hazard[p]                      = rd_hazard_arr[p];
        end
    end

    assign bus.o_pending = pending;

endmodule
